// File: rtl/mem_read_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of the read arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_read_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_busy;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_busy;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic [31:0] memory_address;
  logic        memory_read_strobe;
  logic [31:0] memory_read_data;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, memory_read_data,
    output i_busy, i_valid, i_rdata, d_busy, d_valid, d_rdata,
    output memory_address, memory_read_strobe
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, memory_read_data,
    input  i_busy, i_valid, i_rdata, d_busy, d_valid, d_rdata,
    input  memory_address, memory_read_strobe
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-port read arbiter (fetch I, load D) in front of a single-port memory with
// one-cycle read latency: one pending request per port, strobe, then route data back.
module mem_read_arbiter #(
  parameter int POLICY = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  mem_read_arbiter_if.slave bus
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]        state;
  logic              pend_i, pend_d;
  logic [DATA_W-1:0] addr_i, addr_d;
  logic [DATA_W-1:0] issue_addr;
  logic              strobe;
  logic              grant_d;
  logic              last_d;
  logic              valid_i, valid_d;
  logic [DATA_W-1:0] rdata_i, rdata_d;

  logic in_flight, busy_i, busy_d, any_pend, issue, pick_d;

  // Busy covers both the queued request and the one currently on the memory.
  assign in_flight = (state == READ) || (state == WAIT);
  assign busy_i    = pend_i | (in_flight & ~grant_d);
  assign busy_d    = pend_d | (in_flight &  grant_d);
  assign any_pend  = pend_i | pend_d;
  assign issue     = any_pend && ((state == IDLE) || (state == WAIT));

  always_comb begin
    pick_d = pend_d;
    if (pend_i && pend_d)
      pick_d = (POLICY == 1) ? 1'b1 : ~last_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
      addr_i     <= '0;
      addr_d     <= '0;
      issue_addr <= '0;
      strobe     <= 1'b0;
      grant_d    <= 1'b0;
      last_d     <= 1'b1;
      valid_i    <= 1'b0;
      valid_d    <= 1'b0;
      rdata_i    <= '0;
      rdata_d    <= '0;
    end else begin
      valid_i <= 1'b0;
      valid_d <= 1'b0;

      if (bus.i_req && !busy_i) begin
        pend_i <= 1'b1;
        addr_i <= bus.i_addr;
      end
      if (bus.d_req && !busy_d) begin
        pend_d <= 1'b1;
        addr_d <= bus.d_addr;
      end

      case (state)
        IDLE:    state <= any_pend ? READ : IDLE;
        READ:    state <= WAIT;
        WAIT: begin
          if (grant_d) begin
            rdata_d <= bus.memory_read_data;
            valid_d <= 1'b1;
          end else begin
            rdata_i <= bus.memory_read_data;
            valid_i <= 1'b1;
          end
          state <= any_pend ? READ : IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new grant can start from IDLE or overlap the data phase of WAIT.
      strobe <= issue;
      if (issue) begin
        grant_d    <= pick_d;
        last_d     <= pick_d;
        issue_addr <= pick_d ? addr_d : addr_i;
        if (pick_d)
          pend_d <= 1'b0;
        else
          pend_i <= 1'b0;
      end
    end
  end

  assign bus.i_busy             = busy_i;
  assign bus.d_busy             = busy_d;
  assign bus.i_valid            = valid_i;
  assign bus.d_valid            = valid_d;
  assign bus.i_rdata            = rdata_i;
  assign bus.d_rdata            = rdata_d;
  assign bus.memory_address     = issue_addr;
  assign bus.memory_read_strobe = strobe;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: one round-robin and one fixed-priority
// instance, each with its own one-cycle-latency memory model.
module tb_mem_read_arbiter;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  mem_read_arbiter_if ia();
  mem_read_arbiter_if ib();

  mem_read_arbiter #(.POLICY(0)) ua (.CLK(CLK), .RESET_N(RESET_N), .bus(ia));
  mem_read_arbiter #(.POLICY(1)) ub (.CLK(CLK), .RESET_N(RESET_N), .bus(ib));

  logic [31:0] mem [0:255];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge CLK) begin
    if (ia.memory_read_strobe) ia.memory_read_data <= mem[ia.memory_address[9:2]];
    if (ib.memory_read_strobe) ib.memory_read_data <= mem[ib.memory_address[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    logic [7:0] jb;
    logic       found;
    int         t_req;
    int         last_v;

    for (int j = 0; j < 256; j++) begin
      jb = j[7:0];
      mem[j] = {8'hC0, jb, 8'h5A, ~jb};
    end
    mem[1] = 32'h00100093;

    ia.i_req = 1'b0; ia.i_addr = '0; ia.d_req = 1'b0; ia.d_addr = '0;
    ib.i_req = 1'b0; ib.i_addr = '0; ib.d_req = 1'b0; ib.d_addr = '0;
    ia.memory_read_data = '0;
    ib.memory_read_data = '0;

    // Reset state
    repeat (3) tick();
    chkb("rst_i_busy", ia.i_busy, 1'b0);
    chkb("rst_d_busy", ia.d_busy, 1'b0);
    chkb("rst_i_valid", ia.i_valid, 1'b0);
    chkb("rst_d_valid", ia.d_valid, 1'b0);
    chkb("rst_strobe", ia.memory_read_strobe, 1'b0);
    chk("rst_addr", ia.memory_address, 32'h0);
    chk("rst_i_rdata", ia.i_rdata, 32'h0);
    chk("rst_d_rdata", ib.d_rdata, 32'h0);
    RESET_N = 1'b1;
    tick();

    // Tie right after reset: I wins
    ia.i_req = 1'b1; ia.i_addr = 32'd0; ia.d_req = 1'b1; ia.d_addr = 32'd8;
    tick();
    ia.i_req = 1'b0; ia.d_req = 1'b0;
    chkb("tie1_i_busy0", ia.i_busy, 1'b1);
    chkb("tie1_d_busy0", ia.d_busy, 1'b1);
    tick();
    chkb("tie1_strobe1", ia.memory_read_strobe, 1'b1);
    chk("tie1_addr1", ia.memory_address, 32'd0);
    tick(); tick();
    chkb("tie1_i_valid3", ia.i_valid, 1'b1);
    chk("tie1_i_rdata3", ia.i_rdata, mem[0]);
    chkb("tie1_d_valid3", ia.d_valid, 1'b0);
    chkb("tie1_strobe3", ia.memory_read_strobe, 1'b1);
    chk("tie1_addr3", ia.memory_address, 32'd8);
    tick();
    chkb("tie1_i_valid4", ia.i_valid, 1'b0);
    chkb("tie1_d_valid4", ia.d_valid, 1'b0);
    tick();
    chkb("tie1_d_valid5", ia.d_valid, 1'b1);
    chk("tie1_d_rdata5", ia.d_rdata, mem[2]);
    chk("tie1_i_hold5", ia.i_rdata, mem[0]);
    tick();

    // Single fetch from address 4
    ia.i_req = 1'b1; ia.i_addr = 32'd4;
    tick();
    ia.i_req = 1'b0;
    chkb("single_busy0", ia.i_busy, 1'b1);
    tick();
    chkb("single_busy1", ia.i_busy, 1'b1);
    chkb("single_strobe1", ia.memory_read_strobe, 1'b1);
    chk("single_addr1", ia.memory_address, 32'd4);
    tick();
    chkb("single_busy2", ia.i_busy, 1'b1);
    chkb("single_strobe2", ia.memory_read_strobe, 1'b0);
    chk("single_addr_hold2", ia.memory_address, 32'd4);
    tick();
    chkb("single_valid3", ia.i_valid, 1'b1);
    chk("single_rdata3", ia.i_rdata, 32'h00100093);
    chkb("single_busy3", ia.i_busy, 1'b0);
    chkb("single_d_valid3", ia.d_valid, 1'b0);
    tick();
    chkb("single_valid4", ia.i_valid, 1'b0);

    // Tie with last grant on I: D wins
    ia.i_req = 1'b1; ia.i_addr = 32'd12; ia.d_req = 1'b1; ia.d_addr = 32'd16;
    tick();
    ia.i_req = 1'b0; ia.d_req = 1'b0;
    tick(); tick(); tick();
    chkb("tie2_d_valid3", ia.d_valid, 1'b1);
    chk("tie2_d_rdata3", ia.d_rdata, mem[4]);
    chkb("tie2_i_valid3", ia.i_valid, 1'b0);
    chk("tie2_addr3", ia.memory_address, 32'd12);
    tick(); tick();
    chkb("tie2_i_valid5", ia.i_valid, 1'b1);
    chk("tie2_i_rdata5", ia.i_rdata, mem[3]);
    tick();

    // Request while busy is dropped; request in the valid cycle is taken
    ia.d_req = 1'b1; ia.d_addr = 32'd12;
    tick();
    ia.d_addr = 32'd16;
    chkb("proto_busy0", ia.d_busy, 1'b1);
    tick();
    ia.d_req = 1'b0;
    chk("proto_addr1", ia.memory_address, 32'd12);
    tick();
    tick();
    chkb("proto_valid3", ia.d_valid, 1'b1);
    chk("proto_rdata3", ia.d_rdata, mem[3]);
    chkb("proto_no_strobe3", ia.memory_read_strobe, 1'b0);
    chkb("proto_busy3", ia.d_busy, 1'b0);
    ia.d_req = 1'b1; ia.d_addr = 32'd20;
    tick();
    ia.d_req = 1'b0;
    chkb("proto_valid4", ia.d_valid, 1'b0);
    chkb("proto_busy4", ia.d_busy, 1'b1);
    chk("proto_addr_hold4", ia.memory_address, 32'd12);
    tick();
    chk("proto_addr5", ia.memory_address, 32'd20);
    tick(); tick();
    chkb("proto_valid7", ia.d_valid, 1'b1);
    chk("proto_rdata7", ia.d_rdata, mem[5]);
    tick();

    // Streaming fetches, each issued in the previous valid cycle
    last_v = 0;
    for (int n = 0; n < 8; n++) begin
      ia.i_req = 1'b1; ia.i_addr = 32'(4 * n);
      tick();
      ia.i_req = 1'b0;
      t_req = cyc;
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
        tick();
        if (ia.i_valid) found = 1'b1;
      end
      chkb("stream_valid_seen", found, 1'b1);
      if (found) begin
        chk("stream_rdata", ia.i_rdata, mem[n]);
        chk("stream_latency", 32'(cyc - t_req), 32'd3);
        if (n > 0) chk("stream_interval", 32'(cyc - last_v), 32'd4);
        last_v = cyc;
      end
    end
    tick();

    // Fixed priority instance: D wins every tie
    for (int n = 0; n < 3; n++) begin
      ib.i_req = 1'b1; ib.i_addr = 32'(4 * n);
      ib.d_req = 1'b1; ib.d_addr = 32'(4 * (n + 4));
      tick();
      ib.i_req = 1'b0; ib.d_req = 1'b0;
      tick(); tick(); tick();
      chkb("prio_d_valid3", ib.d_valid, 1'b1);
      chk("prio_d_rdata3", ib.d_rdata, mem[n + 4]);
      chkb("prio_i_valid3", ib.i_valid, 1'b0);
      tick(); tick();
      chkb("prio_i_valid5", ib.i_valid, 1'b1);
      chk("prio_i_rdata5", ib.i_rdata, mem[n]);
      chkb("prio_d_valid5", ib.d_valid, 1'b0);
    end
    tick();

    // Reset during WAIT
    ia.i_req = 1'b1; ia.i_addr = 32'd8;
    tick();
    ia.i_req = 1'b0;
    tick(); tick();
    chkb("mid_busy_before", ia.i_busy, 1'b1);
    RESET_N = 1'b0;
    #1;
    chkb("mid_i_busy", ia.i_busy, 1'b0);
    chkb("mid_strobe", ia.memory_read_strobe, 1'b0);
    chk("mid_addr", ia.memory_address, 32'h0);
    chk("mid_i_rdata", ia.i_rdata, 32'h0);
    chk("mid_d_rdata", ia.d_rdata, 32'h0);
    chkb("mid_i_valid", ia.i_valid, 1'b0);
    tick();
    RESET_N = 1'b1;
    found = 1'b0;
    repeat (6) begin
      tick();
      if (ia.i_valid || ia.d_valid) found = 1'b1;
    end
    chkb("mid_no_valid", found, 1'b0);

    // Tie after reset: I wins again
    ia.i_req = 1'b1; ia.i_addr = 32'd24; ia.d_req = 1'b1; ia.d_addr = 32'd28;
    tick();
    ia.i_req = 1'b0; ia.d_req = 1'b0;
    tick(); tick(); tick();
    chkb("post_i_valid3", ia.i_valid, 1'b1);
    chk("post_i_rdata3", ia.i_rdata, mem[6]);
    chkb("post_d_valid3", ia.d_valid, 1'b0);
    tick(); tick();
    chkb("post_d_valid5", ia.d_valid, 1'b1);
    chk("post_d_rdata5", ia.d_rdata, mem[7]);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
